// File: rtl/excp_ctrl_pkg.sv
// Shared CPU defines for the exception/ERTN controller: FSM state encoding,
// commit-event classes, the interrupt exception code and CSR numbers.
package excp_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CSRW  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FLUSH = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    EV_PLAIN = 3'd0,
    EV_CSRW  = 3'd1,
    EV_ERTN  = 3'd2,
    EV_EXCP  = 3'd3,
    EV_INT   = 3'd4
  } event_t;

  localparam logic [5:0] ECODE_INT = 6'h00;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;

  // Commit-stage priority: interrupt > exception > ERTN > CSR write > plain.
  function automatic event_t classify(input logic has_int, input logic excp,
                                      input logic ertn, input logic csr_we);
    if (has_int)     return EV_INT;
    else if (excp)   return EV_EXCP;
    else if (ertn)   return EV_ERTN;
    else if (csr_we) return EV_CSRW;
    else             return EV_PLAIN;
  endfunction

  function automatic logic is_flush_event(input event_t ev);
    return (ev == EV_INT) || (ev == EV_EXCP) || (ev == EV_ERTN);
  endfunction

endpackage

// File: rtl/excp_ctrl.sv
// Commit-stage exception / ERTN / CSR-write sequencer. Accepts one commit at a
// time, waits for outstanding memory traffic before redirecting the pipeline,
// and holds off further commits for FLUSH_GAP cycles after each flush.
//
//   state | meaning
//   IDLE  | ready to accept a commit
//   CSRW  | registered CSR write is on csr_* this cycle
//   DRAIN | flush pending, waiting for mem_busy to drop
//   FLUSH | one-cycle flush pulse and pipeline redirect
//   GAP   | post-flush stall, gap counter counting down to 0
module excp_ctrl
  import excp_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_GAP = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [31:0] wb_pc,
  input  logic        wb_excp,
  input  logic [5:0]  wb_ecode,
  input  logic [2:0]  wb_esubcode,
  input  logic        wb_ertn,
  input  logic        wb_csr_we,
  input  logic [13:0] wb_csr_num,
  input  logic [31:0] wb_csr_wmask,
  input  logic [31:0] wb_csr_wdata,
  input  logic        mem_busy,
  input  logic        has_int,
  input  logic [31:0] era,
  input  logic [31:0] eentry,
  output logic        csr_we,
  output logic [13:0] csr_num,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wdata,
  output logic        excp_flush,
  output logic        ertn_flush,
  output logic [5:0]  ecode,
  output logic [2:0]  esubcode,
  output logic [31:0] epc,
  output logic        flush_valid,
  output logic [31:0] flush_target
);

  // FLUSH_GAP of 0 skips GAP entirely, so the load value is never used then.
  localparam logic [3:0] GAP_LOAD = (FLUSH_GAP == 0) ? 4'd0 : 4'(FLUSH_GAP - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] gap_cnt;
  logic       is_ertn;
  logic       accept;
  event_t     ev;

  assign accept = wb_valid && (state == ST_IDLE);
  assign ev     = classify(has_int, wb_excp, wb_ertn, wb_csr_we);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_flush_event(ev))  state_nxt = mem_busy ? ST_DRAIN : ST_FLUSH;
          else if (ev == EV_CSRW) state_nxt = ST_CSRW;
        end
      end
      ST_CSRW:  state_nxt = ST_IDLE;
      ST_DRAIN: state_nxt = mem_busy ? ST_DRAIN : ST_FLUSH;
      ST_FLUSH: state_nxt = (FLUSH_GAP == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:   state_nxt = (gap_cnt == 4'd0) ? ST_IDLE : ST_GAP;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; redirect target is sampled live in FLUSH.
  always_comb begin
    wb_ready     = (state == ST_IDLE);
    flush_valid  = (state == ST_FLUSH);
    excp_flush   = (state == ST_FLUSH) && !is_ertn;
    ertn_flush   = (state == ST_FLUSH) && is_ertn;
    flush_target = '0;
    if (state == ST_FLUSH) flush_target = is_ertn ? era : eentry;
  end

  // Post-flush stall timer: loaded in FLUSH, counts down to terminal 0 in GAP.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                               gap_cnt <= 4'd0;
    else if (state == ST_FLUSH)                gap_cnt <= GAP_LOAD;
    else if (state == ST_GAP && gap_cnt != 0)  gap_cnt <= gap_cnt - 4'd1;
  end

  // Capture exception info on accept; ERTN leaves the last exception info intact.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ecode    <= '0;
      esubcode <= '0;
      epc      <= '0;
      is_ertn  <= 1'b0;
    end else if (accept) begin
      case (ev)
        EV_INT: begin
          ecode    <= ECODE_INT;
          esubcode <= 3'd0;
          epc      <= wb_pc;
          is_ertn  <= 1'b0;
        end
        EV_EXCP: begin
          ecode    <= wb_ecode;
          esubcode <= wb_esubcode;
          epc      <= wb_pc;
          is_ertn  <= 1'b0;
        end
        EV_ERTN: is_ertn <= 1'b1;
        default: ;
      endcase
    end
  end

  // Registered CSR write, one-cycle strobe the cycle after accept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      csr_we    <= 1'b0;
      csr_num   <= '0;
      csr_wmask <= '0;
      csr_wdata <= '0;
    end else begin
      csr_we <= accept && (ev == EV_CSRW);
      if (accept && (ev == EV_CSRW)) begin
        csr_num   <= wb_csr_num;
        csr_wmask <= wb_csr_wmask;
        csr_wdata <= wb_csr_wdata;
      end
    end
  end

endmodule

// File: tb/tb_excp_ctrl.sv
// Directed bench for excp_ctrl: one instance with FLUSH_GAP=2, one with
// FLUSH_GAP=0, both driven by the same commit stream.
module tb_excp_ctrl;
  import excp_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_valid, wb_excp, wb_ertn, wb_csr_we, mem_busy, has_int;
  logic [31:0] wb_pc, wb_csr_wmask, wb_csr_wdata, era, eentry;
  logic [5:0]  wb_ecode;
  logic [2:0]  wb_esubcode;
  logic [13:0] wb_csr_num;

  logic        wb_ready_a, csr_we_a, excp_flush_a, ertn_flush_a, flush_valid_a;
  logic [13:0] csr_num_a;
  logic [31:0] csr_wmask_a, csr_wdata_a, epc_a, flush_target_a;
  logic [5:0]  ecode_a;
  logic [2:0]  esubcode_a;

  logic        wb_ready_b, csr_we_b, excp_flush_b, ertn_flush_b, flush_valid_b;
  logic [13:0] csr_num_b;
  logic [31:0] csr_wmask_b, csr_wdata_b, epc_b, flush_target_b;
  logic [5:0]  ecode_b;
  logic [2:0]  esubcode_b;

  int n_vec = 0;
  int n_bad = 0;
  int lo_a, lo_b, n_excp, n_ertn, n_we;

  always #5 clk = ~clk;

  excp_ctrl #(.FLUSH_GAP(2)) dut_a (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_ready(wb_ready_a),
    .wb_pc(wb_pc), .wb_excp(wb_excp), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .wb_ertn(wb_ertn), .wb_csr_we(wb_csr_we), .wb_csr_num(wb_csr_num),
    .wb_csr_wmask(wb_csr_wmask), .wb_csr_wdata(wb_csr_wdata), .mem_busy(mem_busy),
    .has_int(has_int), .era(era), .eentry(eentry), .csr_we(csr_we_a),
    .csr_num(csr_num_a), .csr_wmask(csr_wmask_a), .csr_wdata(csr_wdata_a),
    .excp_flush(excp_flush_a), .ertn_flush(ertn_flush_a), .ecode(ecode_a),
    .esubcode(esubcode_a), .epc(epc_a), .flush_valid(flush_valid_a),
    .flush_target(flush_target_a)
  );

  excp_ctrl #(.FLUSH_GAP(0)) dut_b (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_ready(wb_ready_b),
    .wb_pc(wb_pc), .wb_excp(wb_excp), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .wb_ertn(wb_ertn), .wb_csr_we(wb_csr_we), .wb_csr_num(wb_csr_num),
    .wb_csr_wmask(wb_csr_wmask), .wb_csr_wdata(wb_csr_wdata), .mem_busy(mem_busy),
    .has_int(has_int), .era(era), .eentry(eentry), .csr_we(csr_we_b),
    .csr_num(csr_num_b), .csr_wmask(csr_wmask_b), .csr_wdata(csr_wdata_b),
    .excp_flush(excp_flush_b), .ertn_flush(ertn_flush_b), .ecode(ecode_b),
    .esubcode(esubcode_b), .epc(epc_b), .flush_valid(flush_valid_b),
    .flush_target(flush_target_b)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, want 0x%h", tag, act, exp);
    end
  endtask

  task automatic clear_wb();
    wb_valid     = 1'b0;
    wb_excp      = 1'b0;
    wb_ertn      = 1'b0;
    wb_csr_we    = 1'b0;
    wb_ecode     = '0;
    wb_esubcode  = '0;
    wb_csr_num   = '0;
    wb_csr_wmask = '0;
    wb_csr_wdata = '0;
    has_int      = 1'b0;
  endtask

  // Commit is accepted on the next rising edge, then withdrawn.
  task automatic issue();
    @(posedge clk);
    #1;
    clear_wb();
  endtask

  // Counts stall cycles and pulses until both instances are ready again.
  task automatic run_until_ready(output int la, output int lb, output int ne,
                                 output int nr, output int nw);
    bit done = 0;
    la = 0; lb = 0; ne = 0; nr = 0; nw = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!wb_ready_a) la++;
      if (!wb_ready_b) lb++;
      if (excp_flush_a) ne++;
      if (ertn_flush_a) nr++;
      if (csr_we_a) nw++;
      if (wb_ready_a && wb_ready_b) done = 1;
    end
    if (!done) chk("ready_timeout", {31'd0, wb_ready_a}, 32'd1);
  endtask

  initial begin
    resetn   = 1'b0;
    clear_wb();
    mem_busy = 1'b0;
    wb_pc    = '0;
    era      = '0;
    eentry   = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, wb_ready_a}, 32'd1);
    chk("rst_fvalid", {31'd0, flush_valid_a}, 32'd0);
    chk("rst_csr_we", {31'd0, csr_we_a}, 32'd0);
    chk("rst_epc", epc_a, 32'd0);
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, wb_ready_a}, 32'd1);

    // Exception with memory idle; its CSR write must be suppressed.
    wb_valid = 1'b1; wb_excp = 1'b1; wb_ecode = 6'h0B; wb_esubcode = 3'd0;
    wb_pc = 32'h1C00_0100; wb_csr_we = 1'b1; wb_csr_num = 14'h001; wb_csr_wdata = 32'hDEAD_BEEF;
    eentry = 32'h1C00_8000; era = 32'h1C00_0204; mem_busy = 1'b0;
    issue();
    @(negedge clk);
    chk("t1_excp_flush", {31'd0, excp_flush_a}, 32'd1);
    chk("t1_ertn_flush", {31'd0, ertn_flush_a}, 32'd0);
    chk("t1_fvalid", {31'd0, flush_valid_a}, 32'd1);
    chk("t1_target", flush_target_a, 32'h1C00_8000);
    chk("t1_epc", epc_a, 32'h1C00_0100);
    chk("t1_ecode", {26'd0, ecode_a}, 32'h0B);
    chk("t1_csr_we", {31'd0, csr_we_a}, 32'd0);
    chk("t1b_excp_flush", {31'd0, excp_flush_b}, 32'd1);
    run_until_ready(lo_a, lo_b, n_excp, n_ertn, n_we);
    chk("t1_stall_cycles", lo_a + 1, 32'd3);
    chk("t1b_stall_cycles", lo_b + 1, 32'd1);
    chk("t1_single_pulse", n_excp, 32'd0);
    chk("t1_no_we", n_we, 32'd0);
    chk("t1_target_idle", flush_target_a, 32'd0);

    // ERTN with memory busy for three cycles.
    wb_valid = 1'b1; wb_ertn = 1'b1; mem_busy = 1'b1;
    issue();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_drain_fvalid", {31'd0, flush_valid_a}, 32'd0);
      chk("t2_drain_ready", {31'd0, wb_ready_a}, 32'd0);
      if (i == 1) begin
        @(posedge clk); #1 mem_busy = 1'b0;
      end
    end
    @(negedge clk);
    chk("t2_ertn_flush", {31'd0, ertn_flush_a}, 32'd1);
    chk("t2_excp_flush", {31'd0, excp_flush_a}, 32'd0);
    chk("t2_fvalid", {31'd0, flush_valid_a}, 32'd1);
    chk("t2_target", flush_target_a, 32'h1C00_0204);
    chk("t2_ecode_held", {26'd0, ecode_a}, 32'h0B);
    chk("t2_epc_held", epc_a, 32'h1C00_0100);
    chk("t2b_ertn_flush", {31'd0, ertn_flush_b}, 32'd1);
    run_until_ready(lo_a, lo_b, n_excp, n_ertn, n_we);
    chk("t2_single_pulse", n_ertn, 32'd0);
    chk("t2_stall_cycles", lo_a + 1, 32'd3);

    // Interrupt beats a simultaneous exception and CSR write.
    has_int = 1'b1; wb_valid = 1'b1; wb_excp = 1'b1; wb_ecode = 6'h15; wb_esubcode = 3'd1;
    wb_csr_we = 1'b1; wb_csr_num = 14'h005; wb_csr_wdata = 32'h1234_5678;
    wb_pc = 32'h1C00_0300;
    issue();
    @(negedge clk);
    chk("t3_excp_flush", {31'd0, excp_flush_a}, 32'd1);
    chk("t3_ecode", {26'd0, ecode_a}, 32'h00);
    chk("t3_esubcode", {29'd0, esubcode_a}, 32'd0);
    chk("t3_epc", epc_a, 32'h1C00_0300);
    chk("t3_target", flush_target_a, 32'h1C00_8000);
    chk("t3_csr_we", {31'd0, csr_we_a}, 32'd0);
    run_until_ready(lo_a, lo_b, n_excp, n_ertn, n_we);
    chk("t3_no_we", n_we, 32'd0);

    // CSR write.
    wb_valid = 1'b1; wb_csr_we = 1'b1; wb_csr_num = CSR_EENTRY;
    wb_csr_wmask = 32'hFFFF_FFFF; wb_csr_wdata = 32'h1C00_8000;
    issue();
    @(negedge clk);
    chk("t4_csr_we", {31'd0, csr_we_a}, 32'd1);
    chk("t4_csr_num", {18'd0, csr_num_a}, 32'h0C);
    chk("t4_csr_wmask", csr_wmask_a, 32'hFFFF_FFFF);
    chk("t4_csr_wdata", csr_wdata_a, 32'h1C00_8000);
    chk("t4_ready_low", {31'd0, wb_ready_a}, 32'd0);
    chk("t4_no_flush", {31'd0, flush_valid_a}, 32'd0);
    @(negedge clk);
    chk("t4_we_off", {31'd0, csr_we_a}, 32'd0);
    chk("t4_ready_back", {31'd0, wb_ready_a}, 32'd1);

    // Plain instructions back to back.
    wb_valid = 1'b1; wb_pc = 32'h1C00_0500;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_ready", {31'd0, wb_ready_a}, 32'd1);
      chk("t5_no_pulse", {30'd0, csr_we_a, flush_valid_a}, 32'd0);
    end
    clear_wb();

    // Reset asserted mid-GAP; commits offered during the stall are ignored.
    wb_valid = 1'b1; wb_excp = 1'b1; wb_ecode = 6'h0B; wb_esubcode = 3'd2;
    wb_pc = 32'h1C00_0400;
    issue();
    @(negedge clk);
    chk("t6_flush", {31'd0, excp_flush_a}, 32'd1);
    wb_valid = 1'b1; wb_csr_we = 1'b1; wb_csr_num = 14'h001; wb_csr_wdata = 32'h5;
    @(negedge clk);
    chk("t6_ignored", {31'd0, csr_we_a}, 32'd0);
    chk("t6_in_gap", {31'd0, wb_ready_a}, 32'd0);
    #2 resetn = 1'b0;
    clear_wb();
    #1;
    chk("t6_rst_ready", {31'd0, wb_ready_a}, 32'd1);
    chk("t6_rst_flags", {27'd0, csr_we_a, excp_flush_a, ertn_flush_a, flush_valid_a, 1'b0}, 32'd0);
    chk("t6_rst_ecode", {23'd0, esubcode_a, ecode_a}, 32'd0);
    chk("t6_rst_epc", epc_a, 32'd0);
    chk("t6_rst_target", flush_target_a, 32'd0);
    chk("t6_rst_csr_num", {18'd0, csr_num_a}, 32'd0);
    chk("t6_rst_csr_wmask", csr_wmask_a, 32'd0);
    chk("t6_rst_csr_wdata", csr_wdata_a, 32'd0);
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk);
    chk("t6_ready_after_rst", {31'd0, wb_ready_a}, 32'd1);
    wb_valid = 1'b1; wb_csr_we = 1'b1; wb_csr_num = 14'h001;
    wb_csr_wmask = 32'h0000_00FF; wb_csr_wdata = 32'h0000_00A5;
    issue();
    @(negedge clk);
    chk("t6_post_we", {31'd0, csr_we_a}, 32'd1);
    chk("t6_post_wdata", csr_wdata_a, 32'h0000_00A5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
